// File: rtl/fpu_cmp_unit.sv
// fpu_cmp_unit: RV64D sign-inject, min/max, compare and classify responder on the FPU issue handshake.
// Latency: accept edge + 2 cycles; result and NV land on the edge where busy_o falls, with a done_o pulse.
// Backpressure: no queueing; issues are taken only in IDLE, and enable/operand changes while busy are ignored.
// Optional: define FPU_CMP_SINGLE_EN to also accept the .S (fmt=00) variants with NaN-boxing.
module fpu_cmp_unit #(
   parameter int          FLEN      = 64,
   parameter logic [63:0] CANON_NAN = 64'h7FF8000000000000
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            fpuEnable_i,
   input  logic [31:0]     instr_i,
   input  logic [FLEN-1:0] rs1_i,
   input  logic [FLEN-1:0] rs2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            illegal_o,
   output logic [FLEN-1:0] fpuOut_o,
   output logic [4:0]      fflags_o
);

`ifdef FPU_CMP_SINGLE_EN
   localparam bit SP_EN = 1'b1;
`else
   localparam bit SP_EN = 1'b0;
`endif

   localparam logic [63:0] CANON_NAN_S_BOXED = {32'hFFFFFFFF, 32'h7FC00000};

   typedef enum logic [1:0] {ST_IDLE, ST_CLASSIFY, ST_EXEC} state_t;

   typedef enum logic [3:0] {
      OP_SGNJ, OP_SGNJN, OP_SGNJX, OP_MIN, OP_MAX, OP_EQ, OP_LT, OP_LE, OP_CLASS
   } op_t;

   // Per-operand field summary captured at accept time.
   typedef struct packed {
      logic sign;
      logic exp_ones;
      logic exp_zero;
      logic mant_zero;
      logic mant_msb;
   } cls_t;

   // Field extraction for either format; sp selects the 32-bit layout.
   function automatic cls_t classify(input logic [63:0] x, input logic sp);
      cls_t c;
      if (sp) begin
         c.sign      = x[31];
         c.exp_ones  = &x[30:23];
         c.exp_zero  = ~|x[30:23];
         c.mant_zero = ~|x[22:0];
         c.mant_msb  = x[22];
      end else begin
         c.sign      = x[63];
         c.exp_ones  = &x[62:52];
         c.exp_zero  = ~|x[62:52];
         c.mant_zero = ~|x[51:0];
         c.mant_msb  = x[51];
      end
      return c;
   endfunction

   // Magnitude (everything but the sign) right-aligned for unsigned comparison.
   function automatic logic [63:0] magnitude(input logic [63:0] x, input logic sp);
      return sp ? {33'b0, x[30:0]} : {1'b0, x[62:0]};
   endfunction

   // Single results are NaN-boxed; double results pass straight through.
   function automatic logic [63:0] box(input logic [63:0] x, input logic sp);
      return sp ? {32'hFFFFFFFF, x[31:0]} : x;
   endfunction

   // ---------------------------------------------------------------- state
   state_t      state_q, state_d;
   op_t         op_q, op_d;
   logic        is_sp_q, is_sp_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;
   cls_t        cls_a_q, cls_a_d;
   cls_t        cls_b_q, cls_b_d;
   logic [63:0] res_q, res_d;
   logic        nv_q, nv_d;
   logic [63:0] out_q, out_d;
   logic [4:0]  flags_q, flags_d;
   logic        done_q, done_d;
   logic        illegal_q, illegal_d;

   // ---------------------------------------------------------------- decode
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rs2_fld;
   logic [6:0]  funct7;
   logic        fmt_ok;
   logic        dec_ok;
   op_t         dec_op;
   logic        dec_sp;
   logic [63:0] opa_in;
   logic [63:0] opb_in;
   logic        unused_instr_bits;

   assign opcode            = instr_i[6:0];
   assign funct3            = instr_i[14:12];
   assign rs2_fld           = instr_i[24:20];
   assign funct7            = instr_i[31:25];
   // rd and rs1 register indices belong to the register file, not to this unit.
   assign unused_instr_bits = ^instr_i[19:7];

   // Decode the supported opcode/funct7/funct3 combinations; fmt lives in funct7[1:0].
   always_comb begin
      dec_ok = 1'b0;
      dec_op = OP_SGNJ;
      dec_sp = SP_EN && (funct7[1:0] == 2'b00);
      fmt_ok = (funct7[1:0] == 2'b01) || dec_sp;
      if (opcode == 7'b1010011 && fmt_ok) begin
         case (funct7[6:2])
            5'b00100: begin
               case (funct3)
                  3'b000:  begin dec_ok = 1'b1; dec_op = OP_SGNJ;  end
                  3'b001:  begin dec_ok = 1'b1; dec_op = OP_SGNJN; end
                  3'b010:  begin dec_ok = 1'b1; dec_op = OP_SGNJX; end
                  default: dec_ok = 1'b0;
               endcase
            end
            5'b00101: begin
               case (funct3)
                  3'b000:  begin dec_ok = 1'b1; dec_op = OP_MIN; end
                  3'b001:  begin dec_ok = 1'b1; dec_op = OP_MAX; end
                  default: dec_ok = 1'b0;
               endcase
            end
            5'b10100: begin
               case (funct3)
                  3'b010:  begin dec_ok = 1'b1; dec_op = OP_EQ; end
                  3'b001:  begin dec_ok = 1'b1; dec_op = OP_LT; end
                  3'b000:  begin dec_ok = 1'b1; dec_op = OP_LE; end
                  default: dec_ok = 1'b0;
               endcase
            end
            5'b11100: begin
               if (funct3 == 3'b001 && rs2_fld == 5'd0) begin
                  dec_ok = 1'b1;
                  dec_op = OP_CLASS;
               end
            end
            default: dec_ok = 1'b0;
         endcase
      end
   end

`ifdef FPU_CMP_SINGLE_EN
   // A single operand that is not properly NaN-boxed reads as the canonical single NaN.
   assign opa_in = (dec_sp && !(&rs1_i[63:32])) ? CANON_NAN_S_BOXED : rs1_i;
   assign opb_in = (dec_sp && !(&rs2_i[63:32])) ? CANON_NAN_S_BOXED : rs2_i;
`else
   assign opa_in = rs1_i;
   assign opb_in = rs2_i;
`endif

   // ---------------------------------------------------------------- execute
   logic        nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;
   logic        inf_a, sub_a, norm_a;
   logic [63:0] mag_a, mag_b;
   logic        both_zero, eq_val, lt_signed, lt_val;
   logic        sgn;
   logic [9:0]  class_bits;
   logic [63:0] calc_res;
   logic        calc_nv;

   // Result and NV from the captured operands and their field summaries.
   always_comb begin
      nan_a      = cls_a_q.exp_ones & ~cls_a_q.mant_zero;
      nan_b      = cls_b_q.exp_ones & ~cls_b_q.mant_zero;
      snan_a     = nan_a & ~cls_a_q.mant_msb;
      snan_b     = nan_b & ~cls_b_q.mant_msb;
      zero_a     = cls_a_q.exp_zero & cls_a_q.mant_zero;
      zero_b     = cls_b_q.exp_zero & cls_b_q.mant_zero;
      inf_a      = cls_a_q.exp_ones & cls_a_q.mant_zero;
      sub_a      = cls_a_q.exp_zero & ~cls_a_q.mant_zero;
      norm_a     = ~cls_a_q.exp_ones & ~cls_a_q.exp_zero;
      mag_a      = magnitude(a_q, is_sp_q);
      mag_b      = magnitude(b_q, is_sp_q);
      both_zero  = zero_a & zero_b;
      eq_val     = both_zero || ((cls_a_q.sign == cls_b_q.sign) && (mag_a == mag_b));
      // Strict sign-magnitude order in which -0 sits below +0; negative pairs reverse.
      if (cls_a_q.sign != cls_b_q.sign) begin
         lt_signed = cls_a_q.sign;
      end else if (cls_a_q.sign) begin
         lt_signed = mag_a > mag_b;
      end else begin
         lt_signed = mag_a < mag_b;
      end
      lt_val     = lt_signed & ~both_zero;
      class_bits = {nan_a & cls_a_q.mant_msb, snan_a,
                    ~cls_a_q.sign & inf_a, ~cls_a_q.sign & norm_a, ~cls_a_q.sign & sub_a,
                    ~cls_a_q.sign & zero_a,
                    cls_a_q.sign & zero_a, cls_a_q.sign & sub_a, cls_a_q.sign & norm_a,
                    cls_a_q.sign & inf_a};
      sgn        = cls_b_q.sign;
      calc_res   = 64'd0;
      calc_nv    = 1'b0;
      case (op_q)
         OP_SGNJ, OP_SGNJN, OP_SGNJX: begin
            if (op_q == OP_SGNJN) sgn = ~cls_b_q.sign;
            if (op_q == OP_SGNJX) sgn = cls_a_q.sign ^ cls_b_q.sign;
            calc_res = is_sp_q ? {32'hFFFFFFFF, sgn, a_q[30:0]} : {sgn, a_q[62:0]};
         end
         OP_MIN, OP_MAX: begin
            calc_nv = snan_a | snan_b;
            if (nan_a && nan_b) begin
               calc_res = is_sp_q ? CANON_NAN_S_BOXED : CANON_NAN;
            end else if (nan_a) begin
               calc_res = box(b_q, is_sp_q);
            end else if (nan_b) begin
               calc_res = box(a_q, is_sp_q);
            end else if ((op_q == OP_MIN) == lt_signed) begin
               calc_res = box(a_q, is_sp_q);
            end else begin
               calc_res = box(b_q, is_sp_q);
            end
         end
         OP_EQ: begin
            calc_nv  = snan_a | snan_b;
            calc_res = {63'd0, eq_val & ~nan_a & ~nan_b};
         end
         OP_LT, OP_LE: begin
            calc_nv  = nan_a | nan_b;
            calc_res = {63'd0, ~nan_a & ~nan_b & (lt_val | ((op_q == OP_LE) & eq_val))};
         end
         OP_CLASS: begin
            calc_res = {54'd0, class_bits};
         end
         default: calc_res = 64'd0;
      endcase
   end

   // ---------------------------------------------------------------- control
   // Next-state and register-load logic for IDLE -> CLASSIFY -> EXEC -> IDLE.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      is_sp_d   = is_sp_q;
      a_d       = a_q;
      b_d       = b_q;
      cls_a_d   = cls_a_q;
      cls_b_d   = cls_b_q;
      res_d     = res_q;
      nv_d      = nv_q;
      out_d     = out_q;
      flags_d   = flags_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fpuEnable_i) begin
               if (dec_ok) begin
                  op_d    = dec_op;
                  is_sp_d = dec_sp;
                  a_d     = opa_in;
                  b_d     = opb_in;
                  cls_a_d = classify(opa_in, dec_sp);
                  cls_b_d = classify(opb_in, dec_sp);
                  state_d = ST_CLASSIFY;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         ST_CLASSIFY: begin
            res_d   = calc_res;
            nv_d    = calc_nv;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            out_d   = res_q;
            flags_d = {nv_q, 4'b0000};
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight op immediately.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_SGNJ;
         is_sp_q   <= 1'b0;
         a_q       <= 64'd0;
         b_q       <= 64'd0;
         cls_a_q   <= '0;
         cls_b_q   <= '0;
         res_q     <= 64'd0;
         nv_q      <= 1'b0;
         out_q     <= 64'd0;
         flags_q   <= 5'd0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         is_sp_q   <= is_sp_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cls_a_q   <= cls_a_d;
         cls_b_q   <= cls_b_d;
         res_q     <= res_d;
         nv_q      <= nv_d;
         out_q     <= out_d;
         flags_q   <= flags_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end

   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = done_q;
   assign illegal_o = illegal_q;
   assign fpuOut_o  = out_q[FLEN-1:0];
   assign fflags_o  = flags_q;

endmodule

// File: tb/tb_fpu_cmp_unit.sv
// Directed bench for fpu_cmp_unit: hand-computed vectors, immediate-assertion checks.
// Every op also verifies the 2-cycle busy window and the single done_o pulse.
// Issues are driven on the falling edge and sampled 1 time unit after the rising edge.
module tb_fpu_cmp_unit;

   logic        clk;
   logic        rst_n;
   logic        fpu_en;
   logic [31:0] instr;
   logic [63:0] rs1;
   logic [63:0] rs2;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [63:0] fpu_out;
   logic [4:0]  fflags;

   int vectors;
   int miscompares;

   fpu_cmp_unit dut (
      .clk_i       (clk),
      .reset_i     (rst_n),
      .fpuEnable_i (fpu_en),
      .instr_i     (instr),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .busy_o      (busy),
      .done_o      (done),
      .illegal_o   (illegal),
      .fpuOut_o    (fpu_out),
      .fflags_o    (fflags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2f,
                                       input logic [2:0] f3);
      return {f7, rs2f, 5'd1, f3, 5'd2, 7'b1010011};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op and walk the accept/CLASSIFY/EXEC edges; returns in the done_o cycle.
   task automatic run_op(input string tag, input logic [31:0] ins,
                         input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      fpu_en = 1'b1;
      instr  = ins;
      rs1    = a;
      rs2    = b;
      @(posedge clk); #1;
      chk({tag, " busy c1"}, {63'd0, busy}, 64'd1);
      chk({tag, " done c1"}, {63'd0, done}, 64'd0);
      // Garbage issue while busy must be ignored (no illegal, no operand change).
      instr = enc(7'b0000001, 5'd0, 3'b000);
      rs1   = {$urandom, $urandom};
      rs2   = {$urandom, $urandom};
      @(posedge clk); #1;
      chk({tag, " busy c2"}, {63'd0, busy}, 64'd1);
      chk({tag, " illegal c2"}, {63'd0, illegal}, 64'd0);
      @(posedge clk); #1;
      fpu_en = 1'b0;
      chk({tag, " busy end"}, {63'd0, busy}, 64'd0);
      chk({tag, " done"}, {63'd0, done}, 64'd1);
   endtask

   localparam logic [6:0] F7_SGNJ  = 7'b0010001;
   localparam logic [6:0] F7_MINMAX = 7'b0010101;
   localparam logic [6:0] F7_CMP   = 7'b1010001;
   localparam logic [6:0] F7_CLASS = 7'b1110001;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n  = 1'b0;
      fpu_en = 1'b0;
      instr  = 32'd0;
      rs1    = 64'd0;
      rs2    = 64'd0;
      #12;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset illegal", {63'd0, illegal}, 64'd0);
      chk("reset out", fpu_out, 64'd0);
      chk("reset flags", {59'd0, fflags}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("feq 1==1", enc(F7_CMP, 5'd0, 3'b010), 64'h3FF0000000000000, 64'h3FF0000000000000);
      chk("feq 1==1 out", fpu_out, 64'd1);
      chk("feq 1==1 flags", {59'd0, fflags}, 64'd0);

      run_op("flt qnan", enc(F7_CMP, 5'd0, 3'b001), 64'h7FF8000000000000, 64'h3FF0000000000000);
      chk("flt qnan out", fpu_out, 64'd0);
      chk("flt qnan flags", {59'd0, fflags}, 64'h10);

      run_op("feq qnan", enc(F7_CMP, 5'd0, 3'b010), 64'h7FF8000000000000, 64'h3FF0000000000000);
      chk("feq qnan out", fpu_out, 64'd0);
      chk("feq qnan flags", {59'd0, fflags}, 64'd0);

      run_op("fmin -0,+0", enc(F7_MINMAX, 5'd0, 3'b000), 64'h8000000000000000, 64'd0);
      chk("fmin -0,+0 out", fpu_out, 64'h8000000000000000);
      chk("fmin -0,+0 flags", {59'd0, fflags}, 64'd0);

      run_op("fmax -0,+0", enc(F7_MINMAX, 5'd0, 3'b001), 64'h8000000000000000, 64'd0);
      chk("fmax -0,+0 out", fpu_out, 64'd0);

      run_op("fmax snan", enc(F7_MINMAX, 5'd0, 3'b001), 64'h7FF0000000000001, 64'h4000000000000000);
      chk("fmax snan out", fpu_out, 64'h4000000000000000);
      chk("fmax snan flags", {59'd0, fflags}, 64'h10);

      run_op("fmax 2qnan", enc(F7_MINMAX, 5'd0, 3'b001), 64'h7FF8000000000001, 64'hFFF8000000000000);
      chk("fmax 2qnan out", fpu_out, 64'h7FF8000000000000);
      chk("fmax 2qnan flags", {59'd0, fflags}, 64'd0);

      run_op("flt -2<-1", enc(F7_CMP, 5'd0, 3'b001), 64'hC000000000000000, 64'hBFF0000000000000);
      chk("flt -2<-1 out", fpu_out, 64'd1);

      run_op("fle +0,-0", enc(F7_CMP, 5'd0, 3'b000), 64'd0, 64'h8000000000000000);
      chk("fle +0,-0 out", fpu_out, 64'd1);

      run_op("flt +0,-0", enc(F7_CMP, 5'd0, 3'b001), 64'd0, 64'h8000000000000000);
      chk("flt +0,-0 out", fpu_out, 64'd0);
      chk("flt +0,-0 flags", {59'd0, fflags}, 64'd0);

      run_op("fsgnjx", enc(F7_SGNJ, 5'd0, 3'b010), 64'hBFF0000000000000, 64'hC000000000000000);
      chk("fsgnjx out", fpu_out, 64'h3FF0000000000000);

      run_op("fsgnjn", enc(F7_SGNJ, 5'd0, 3'b001), 64'h3FF0000000000000, 64'h3FF0000000000000);
      chk("fsgnjn out", fpu_out, 64'hBFF0000000000000);

      run_op("fclass -0", enc(F7_CLASS, 5'd0, 3'b001), 64'h8000000000000000, 64'd0);
      chk("fclass -0 out", fpu_out, 64'h8);

      run_op("fclass snan", enc(F7_CLASS, 5'd0, 3'b001), 64'h7FF0000000000001, 64'd0);
      chk("fclass snan out", fpu_out, 64'h100);

      run_op("fclass +sub", enc(F7_CLASS, 5'd0, 3'b001), 64'h0000000000000001, 64'd0);
      chk("fclass +sub out", fpu_out, 64'h20);

      run_op("fclass +inf", enc(F7_CLASS, 5'd0, 3'b001), 64'h7FF0000000000000, 64'd0);
      chk("fclass +inf out", fpu_out, 64'h80);

      // FADD.D is not ours: illegal pulse, no busy, outputs untouched.
      @(negedge clk);
      fpu_en = 1'b1;
      instr  = enc(7'b0000001, 5'd3, 3'b000);
      @(posedge clk); #1;
      fpu_en = 1'b0;
      chk("fadd illegal", {63'd0, illegal}, 64'd1);
      chk("fadd busy", {63'd0, busy}, 64'd0);
      chk("fadd out held", fpu_out, 64'h80);
      @(posedge clk); #1;
      chk("fadd illegal drop", {63'd0, illegal}, 64'd0);

      // FEQ.S (fmt=00) is rejected in the default build.
      @(negedge clk);
      fpu_en = 1'b1;
      instr  = enc(7'b1010000, 5'd0, 3'b010);
      @(posedge clk); #1;
      fpu_en = 1'b0;
      chk("feq.s illegal", {63'd0, illegal}, 64'd1);
      chk("feq.s busy", {63'd0, busy}, 64'd0);

      // Reset during EXEC drops the op at once.
      @(negedge clk);
      fpu_en = 1'b1;
      instr  = enc(F7_CMP, 5'd0, 3'b010);
      rs1    = 64'h3FF0000000000000;
      rs2    = 64'h3FF0000000000000;
      @(posedge clk); #1;
      fpu_en = 1'b0;
      @(posedge clk); #1;
      chk("rst mid busy before", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst mid busy", {63'd0, busy}, 64'd0);
      chk("rst mid out", fpu_out, 64'd0);
      chk("rst mid done", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
      chk("rst mid no done", {63'd0, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("fle 1<=2", enc(F7_CMP, 5'd0, 3'b000), 64'h3FF0000000000000, 64'h4000000000000000);
      chk("fle 1<=2 out", fpu_out, 64'd1);
      @(posedge clk); #1;
      chk("done pulse width", {63'd0, done}, 64'd0);
      chk("out holds", fpu_out, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fpu_cmp_unit.md
Name: fpu_cmp_unit

Overview:
- Multi-cycle responder on the FPU issue interface: `fpuEnable_i`, `instr_i` and `rs*_i` in; `busy_o`, `fpuOut_o` and `fflags_o` out.
- Executes the RV64D non-arithmetic FP ops: FSGNJ/FSGNJN/FSGNJX.D, FMIN/FMAX.D, FEQ/FLT/FLE.D and FCLASS.D.
- Sits beside the FPU arithmetic datapath. It reuses the same handshake, so the same issuing logic or bench drives either block.

Parameters:
- FLEN, 64, operand and result width.
- CANON_NAN, 64'h7FF8000000000000, canonical quiet NaN returned when FMIN/FMAX gets two NaN inputs.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  reset, asynchronous assert, active-low; all state cleared while low.
- fpuEnable_i  in  1  issue request.
- instr_i  in  32  full instruction word; decodes opcode[6:0], funct3[14:12], rs2 field[24:20], funct7[31:25].
- rs1_i  in  FLEN  operand A.
- rs2_i  in  FLEN  operand B.
- busy_o  out  1  operation in flight.
- done_o  out  1  one-cycle pulse; result valid.
- illegal_o  out  1  one-cycle pulse; request rejected.
- fpuOut_o  out  FLEN  result; compare and class results are zero-extended.
- fflags_o  out  5  {NV,DZ,OF,UF,NX}; only NV (bit 4) is ever set.

Behaviour:
- Reset values: state IDLE; busy_o, done_o and illegal_o = 0; fpuOut_o = 0; fflags_o = 0.
- Supported decode: opcode 1010011 with one of the following.
  - funct7 0010001, funct3 000/001/010: SGNJ / SGNJN / SGNJX.
  - funct7 0010101, funct3 000/001: MIN / MAX.
  - funct7 1010001, funct3 010/001/000: EQ / LT / LE.
  - funct7 1110001, funct3 001, rs2 field 0: CLASS.
- Accept rule: at a rising edge with state IDLE and fpuEnable_i = 1.
  - Supported decode: capture the op, rs1_i and rs2_i into internal registers; go to CLASSIFY.
  - Anything else: illegal_o = 1 for one cycle; state stays IDLE; outputs unchanged.
- State sequence:
  - IDLE -> CLASSIFY. Registers per operand: sign, exp-all-ones, exp-zero, mant-zero, mant MSB.
  - CLASSIFY -> EXEC. Computes the result and NV.
  - EXEC -> IDLE. Writes fpuOut_o and fflags_o; pulses done_o.
- Timing: busy_o = 1 in CLASSIFY and EXEC, exactly 2 cycles. fpuOut_o/fflags_o update on the edge where busy_o falls and then hold until the next completion.
- Back-to-back: an issue in the done_o cycle is accepted (state is IDLE). fpuEnable_i and operand changes while busy_o = 1 are ignored.
- NaN definitions: sNaN = exp all-ones, mant ≠ 0, mant MSB 0. qNaN = mant MSB 1.
- SGNJ family:
  - Result = {s, rs1[62:0]}.
  - s = rs2 sign for SGNJ, its inverse for SGNJN, and rs1 sign XOR rs2 sign for SGNJX.
  - Never raises flags; NaNs pass through unmodified.
- MIN/MAX:
  - -0 is treated as less than +0.
  - One NaN input: return the other operand. Both NaN: return CANON_NAN.
  - NV set if either input is sNaN.
- EQ: result 1 or 0; +0 == -0; any NaN gives 0. NV set only if an input is sNaN.
- LT/LE: +0 and -0 compare equal; any NaN gives 0 with NV set.
- Comparison method: sign-magnitude. When both operands are negative, the magnitude ordering is reversed.
- CLASS: result has exactly one bit set, zero-extended.
  - Bits 0–4: -inf, -normal, -subnormal, -0, +0.
  - Bits 5–7: +subnormal, +normal, +inf.
  - Bits 8–9: sNaN, qNaN.
  - No flags.
- Reset asserted mid-operation: immediately returns to IDLE with all outputs 0; the in-flight op is dropped with no done_o.

Optional Feature:
- Macro: FPU_CMP_SINGLE_EN.
- Defined: fmt field instr[26:25] = 00 (.S variants) is also accepted.
  - Operands are valid only if NaN-boxed (bits[63:32] all ones); an improperly boxed operand is treated as CANON_NAN_S (32'h7FC00000).
  - SGNJ/MIN/MAX results are NaN-boxed: {32'hFFFFFFFF, result32}.
  - Compare/CLASS operate on the 32-bit fields.
- Undefined: only fmt = 01 decodes; fmt = 00 raises illegal_o.

Test Plan:
- FEQ.D rs1 = rs2 = 64'h3FF0000000000000 -> busy_o high exactly 2 cycles; done_o pulse; fpuOut_o = 1; fflags_o = 0.
- FLT.D rs1 = 64'h7FF8000000000000, rs2 = 64'h3FF0000000000000 -> fpuOut_o = 0, fflags_o = 5'b10000. FEQ.D on the same operands -> 0, fflags_o = 0.
- FMIN.D rs1 = 64'h8000000000000000, rs2 = 0 -> 64'h8000000000000000. FMAX.D on the same operands -> 0. Both ops issued back-to-back in the done_o cycle.
- FMAX.D rs1 = 64'h7FF0000000000001 (sNaN), rs2 = 64'h4000000000000000 -> 64'h4000000000000000, NV = 1. Both operands qNaN -> CANON_NAN, NV = 0.
- FCLASS.D rs1 = 64'h7FF0000000000000 -> 64'h80. FSGNJN.D rs1 = rs2 = 64'h3FF0000000000000 -> 64'hBFF0000000000000.
- FADD.D encoding (funct7 0000001) -> illegal_o pulse, busy_o stays 0. FEQ.D with reset_i driven low during EXEC -> busy_o = 0 and fpuOut_o = 0 at once, no done_o.
